// File: rtl/board_led_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : board_led_pkg
//  Description : Shared constants, register map and LED source encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
package board_led_pkg;

    localparam int          c_led_n        = 4;

    localparam logic [2:0]  c_addr_ctrl    = 3'd0;
    localparam logic [2:0]  c_addr_static  = 3'd1;
    localparam logic [2:0]  c_addr_mode    = 3'd2;
    localparam logic [2:0]  c_addr_halfper = 3'd3;
    localparam logic [2:0]  c_addr_status  = 3'd4;

    localparam logic [3:0]  c_static_rst   = 4'hF;
    localparam logic [7:0]  c_mode_rst     = 8'h00;
    localparam logic [15:0] c_halfper_rst  = 16'd500;

    typedef enum logic [1:0] {
        MODE_STATIC = 2'b00,
        MODE_BLINK  = 2'b01,
        MODE_EVENT  = 2'b10,
        MODE_OFF    = 2'b11
    } led_mode_e;

    function automatic logic led_select(input led_mode_e i_mode, input logic i_static,
                                        input logic i_phase, input logic i_event);
        logic w_out;
        case (i_mode)
            MODE_STATIC: w_out = i_static;
            MODE_BLINK:  w_out = i_phase;
            MODE_EVENT:  w_out = i_event;
            default:     w_out = 1'b0;
        endcase
        return w_out;
    endfunction

endpackage
`default_nettype wire

// File: rtl/led_stretch.sv
`default_nettype none
// ============================================================================
//  Module      : led_stretch
//  Description : Reloadable tick down-counter that keeps an LED lit after an event.
//  Revision    : 1.0 - initial release
// ============================================================================
module led_stretch #(
    parameter int STRETCH_TCK = 100
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_en,
    input  logic i_tick,
    input  logic i_evt,
    output logic o_active
);

    localparam int c_cnt_w = (STRETCH_TCK > 0) ? $clog2(STRETCH_TCK + 1) : 1;
    localparam logic [c_cnt_w-1:0] c_reload = c_cnt_w'(STRETCH_TCK);

    logic [c_cnt_w-1:0] r_scnt;

    // A fresh event outranks a coincident tick so retriggers always restart the full window.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_scnt <= '0;
        end else if (!i_en) begin
            r_scnt <= '0;
        end else if (i_evt) begin
            r_scnt <= c_reload;
        end else if (i_tick && (r_scnt != '0)) begin
            r_scnt <= r_scnt - 1'b1;
        end
    end

    assign o_active = (r_scnt != '0);

endmodule
`default_nettype wire

// File: rtl/board_led_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : board_led_ctrl
//  Description : Avalon-MM LED sequencer: static / blink / event-stretch per LED.
//  Revision    : 1.0 - initial release
// ============================================================================
module board_led_ctrl
    import board_led_pkg::*;
#(
    parameter int         CLK_DIV     = 50000,
    parameter int         STRETCH_TCK = 100,
    parameter logic [3:0] RST_PATTERN = c_static_rst
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic [3:0]  evt_i,
    output logic [3:0]  led_o
);

    localparam int c_presc_w = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_presc_w-1:0] c_presc_last = c_presc_w'(CLK_DIV - 1);

    logic                 w_wr;
    logic                 w_wr_halfper;
    logic                 w_tick;
    logic [15:0]          w_bcnt_last;
    logic [c_led_n-1:0]   w_active;
    logic [c_led_n-1:0]   w_led_sel;

    logic                 r_enable;
    logic [3:0]           r_static;
    logic [7:0]           r_mode;
    logic [15:0]          r_halfper;
    logic [c_presc_w-1:0] r_presc;
    logic [15:0]          r_bcnt;
    logic                 r_phase;

    assign w_wr         = chipselect & ~write_n;
    assign w_wr_halfper = w_wr && (address == c_addr_halfper);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_enable  <= 1'b0;
            r_static  <= RST_PATTERN;
            r_mode    <= c_mode_rst;
            r_halfper <= c_halfper_rst;
        end else if (w_wr) begin
            case (address)
                c_addr_ctrl:    r_enable  <= writedata[0];
                c_addr_static:  r_static  <= writedata[3:0];
                c_addr_mode:    r_mode    <= writedata[7:0];
                c_addr_halfper: r_halfper <= writedata[15:0];
                default:        ;
            endcase
        end
    end

    assign w_tick = r_enable && (r_presc == c_presc_last);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_presc <= '0;
        end else if (!r_enable || w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    // A half-period of zero behaves as one tick.
    assign w_bcnt_last = (r_halfper == 16'd0) ? 16'd0 : (r_halfper - 16'd1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bcnt  <= '0;
            r_phase <= 1'b0;
        end else if (w_wr_halfper || !r_enable) begin
            r_bcnt  <= '0;
            r_phase <= 1'b0;
        end else if (w_tick) begin
            if (r_bcnt == w_bcnt_last) begin
                r_bcnt  <= '0;
                r_phase <= ~r_phase;
            end else begin
                r_bcnt  <= r_bcnt + 16'd1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < c_led_n; gi++) begin : g_stretch
            led_stretch #(
                .STRETCH_TCK (STRETCH_TCK)
            ) u_led_stretch (
                .clk      (clk),
                .reset_n  (reset_n),
                .i_en     (r_enable),
                .i_tick   (w_tick),
                .i_evt    (evt_i[gi]),
                .o_active (w_active[gi])
            );
        end
    endgenerate

    always_comb begin
        w_led_sel = '0;
        for (int i = 0; i < c_led_n; i++) begin
            w_led_sel[i] = led_select(led_mode_e'(r_mode[2*i +: 2]), r_static[i],
                                      r_phase, w_active[i]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            led_o <= RST_PATTERN;
        end else if (!r_enable) begin
            led_o <= r_static;
        end else begin
            led_o <= w_led_sel;
        end
    end

    always_comb begin
        readdata = 32'd0;
        case (address)
            c_addr_ctrl:    readdata = {31'd0, r_enable};
            c_addr_static:  readdata = {28'd0, r_static};
            c_addr_mode:    readdata = {24'd0, r_mode};
            c_addr_halfper: readdata = {16'd0, r_halfper};
            c_addr_status:  readdata = {24'd0, w_active, led_o};
            default:        readdata = 32'd0;
        endcase
    end

endmodule
`default_nettype wire
